// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Bridges a single-outstanding CPU load/store request onto a simple
// synchronous memory port with combinational read data. Byte and halfword
// accesses are supported. A misaligned halfword is either split into two
// byte accesses (SPLIT_MISALIGNED = 1) or forced aligned by clearing
// addr[0] (SPLIT_MISALIGNED = 0).
//
// Ports
//   CLK, RESET            clock, asynchronous active-high reset
//   req_valid / req_ready request handshake (ready only while idle)
//   req_we, req_size      1 = store / 1 = halfword
//   req_signed            sign-extend byte loads
//   req_addr, req_wdata   byte address, store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            load result (0 after a store), held until next resp
//   wmem, memc            memory write strobe, 0 = byte / 1 = halfword
//   DAddress, DataIn      memory address, memory write data
//   DataOut               combinational memory read data
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned SPLIT_MISALIGNED = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        wmem,
    output logic [15:0] DAddress,
    output logic [15:0] DataIn,
    output logic        memc,
    input  logic [15:0] DataOut
);

    typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;

    state_e      state_q, state_d;
    logic        we_q, size_q, signed_q;
    logic [15:0] addr_q, wdata_q;
    logic [7:0]  lo_q;      // low byte captured by the first half of a split load
    logic [15:0] rdata_q, rdata_d;

    logic accept;
    logic split_w;
    logic cap_lo;
    logic cap_final;

    assign accept  = req_valid && req_ready;
    assign split_w = (SPLIT_MISALIGNED != 0) && size_q && addr_q[0];

    // Load result formed at the edge that ends the final memory cycle.
    always_comb begin
        rdata_d = 16'h0000;
        if (we_q) begin
            rdata_d = 16'h0000;
        end else if (state_q == StSplit) begin
            rdata_d = {DataOut[7:0], lo_q};
        end else if (size_q) begin
            rdata_d = DataOut;
        end else if (signed_q) begin
            rdata_d = {{8{DataOut[7]}}, DataOut[7:0]};
        end else begin
            rdata_d = {8'h00, DataOut[7:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        wmem       = 1'b0;
        memc       = 1'b0;
        DAddress   = 16'h0000;
        DataIn     = 16'h0000;
        cap_lo     = 1'b0;
        cap_final  = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                wmem = we_q;
                if (split_w) begin
                    DAddress = addr_q;
                    DataIn   = {8'h00, wdata_q[7:0]};
                    cap_lo   = 1'b1;
                    state_d  = StSplit;
                end else begin
                    // Halfword: clearing addr[0] is a no-op when aligned and forces
                    // alignment when splitting is disabled.
                    DAddress  = size_q ? {addr_q[15:1], 1'b0} : addr_q;
                    memc      = size_q;
                    DataIn    = wdata_q;
                    cap_final = 1'b1;
                    state_d   = StResp;
                end
            end
            StSplit: begin
                wmem      = we_q;
                DAddress  = addr_q + 16'd1;
                DataIn    = {8'h00, wdata_q[15:8]};
                cap_final = 1'b1;
                state_d   = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            size_q   <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            lo_q     <= 8'h00;
            rdata_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (cap_lo) begin
                lo_q <= DataOut[7:0];
            end
            if (cap_final) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign resp_rdata = rdata_q;

endmodule
